// File: rtl/hubris_pkg.sv
// Shared constants and types for the instruction fetch path.
package hubris_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    // What happens to a memory response in the cycle it arrives.
    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_DROP,
        RSP_KEEP,
        RSP_BYPASS
    } rsp_action_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
// head_data shows the oldest entry; pops on empty and pushes on full
// (without a same-cycle pop) are ignored.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against occupancy and clear conditions.
    always_comb begin
        do_pop  = pop && (cnt != '0) && !reset && !flush;
        do_push = push && ((cnt != FULL_CNT) || do_pop) && !reset && !flush;
    end

    // Pointer and count state; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    assign head_data = store[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests under a credit
// limit, queues returned words with their pcs, and handles EX redirects by
// flushing the queue and dropping responses still in flight.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response
// straight to the output when the queue is empty.
module inst_fetch_queue
    import hubris_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]  START_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [WORD_WIDTH-1:0]  mem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   out_valid,
    output logic [WORD_WIDTH-1:0]  out_inst,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    input  logic                   out_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic [CNT_W-1:0]      drop_cnt;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W:0]        in_use;

    logic                  req_fire;
    logic                  rsp_ok;
    rsp_action_e           rsp_action;
    logic                  byp_valid;

    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [CNT_W-1:0]      af_count;

    logic                  q_push;
    logic                  q_pop;
    logic                  q_valid;
    logic [CNT_W-1:0]      q_count;
    logic [WORD_WIDTH-1:0] q_head_inst;
    logic [ADDR_WIDTH-1:0] q_head_pc;

    // Address of every accepted request, consumed by each response in order.
    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_ok),
        .head_data (rsp_pc),
        .count     (af_count)
    );

    // Instruction/pc queue presented to decode.
    fetch_fifo #(
        .WIDTH (WORD_WIDTH + ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data ({mem_rsp_data, rsp_pc}),
        .pop       (q_pop),
        .head_data ({q_head_inst, q_head_pc}),
        .count     (q_count)
    );

    assign occupancy = q_count;
    assign q_valid   = (q_count != '0);

    // Request issue under the credit rule; counts are held clear in reset.
    always_comb begin
        in_use        = {1'b0, occupancy} + {1'b0, outstanding};
        mem_req_valid = !reset && !redirect_valid
                        && (in_use < (CNT_W + 1)'(DEPTH))
                        && (af_count != DEPTH_CNT);
        mem_req_addr  = fetch_pc;
        req_fire      = mem_req_valid && mem_req_ready;
        rsp_ok        = mem_rsp_valid && !reset && (af_count != '0);
        outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_ok);
    end

    // Classify the incoming response: drop, forward, or queue.
    always_comb begin
        rsp_action = RSP_NONE;
        byp_valid  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_valid  = rsp_ok && !redirect_valid && (drop_cnt == '0) && !q_valid;
`endif
        if (rsp_ok) begin
            if (redirect_valid || (drop_cnt != '0)) begin
                rsp_action = RSP_DROP;
            end else if (byp_valid && out_ready) begin
                rsp_action = RSP_BYPASS;
            end else begin
                rsp_action = RSP_KEEP;
            end
        end
        q_push = (rsp_action == RSP_KEEP);
        q_pop  = q_valid && out_ready && !redirect_valid;
    end

    // Output selection: queue head first, then a forwarded response, else NOP.
    always_comb begin
        out_valid = 1'b0;
        out_inst  = NOP_INST;
        out_pc    = START_ADDR;
        if (!reset) begin
            out_pc = fetch_pc;
            if (q_valid) begin
                out_valid = 1'b1;
                out_inst  = q_head_inst;
                out_pc    = q_head_pc;
            end else if (byp_valid) begin
                out_valid = 1'b1;
                out_inst  = mem_rsp_data;
                out_pc    = rsp_pc;
            end
        end
    end

    // Fetch pc, in-flight count and drop count. On redirect the drop count
    // takes the post-cycle outstanding value, so a response landing in the
    // redirect cycle is already excluded from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= START_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                if (rsp_action == RSP_DROP) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue (DEPTH=4, ADDR_WIDTH=32, START_ADDR=0).
// Memory model returns words in order after a programmable latency and
// accepts a bounded number of requests per phase.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    int overflow = 0;

    logic [31:0] exp_pc[$];

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          budget = 0;
    int          mem_lat = 1;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    inst_fetch_queue #(
        .ADDR_WIDTH (32),
        .DEPTH      (4),
        .START_ADDR (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_pc.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, exp_pc.size(), 0);
        exp_pc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Memory model: samples handshakes at negedge, updates just after posedge.
    initial begin
        logic        s_acc;
        logic        s_rsp;
        logic [31:0] s_addr;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            s_acc  = mem_req_valid && mem_req_ready;
            s_addr = mem_req_addr;
            s_rsp  = mem_rsp_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
                acc_cnt = 0;
            end else begin
                if (s_rsp) begin
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (s_acc) begin
                    pend_addr.push_back(s_addr);
                    pend_due.push_back(cyc + mem_lat - 1);
                    acc_cnt++;
                end
            end
            if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = inst_of(pend_addr[0]);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end
            mem_req_ready = (acc_cnt < budget);
        end
    end

    // Monitor: compare every consumed head against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !redirect_valid) begin
                if (exp_pc.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got pc %h with nothing expected", out_pc);
                end else begin
                    e = exp_pc.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_inst", out_inst, inst_of(e));
                end
            end
        end
    end

    // Queue must never receive a push it cannot hold.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && dut.q_push && (dut.q_count == 3'd4) && !dut.q_pop) overflow++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gaps;

        // Reset values, then continuous streaming with 1-cycle memory.
        mem_lat = 1;
        budget  = 8;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_pc.push_back(32'(i * 4));
        tick();
        tick();
        @(negedge clk);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 32'h0000_0013);
        check("rst_out_pc", out_pc, 32'h0);
        tick();
        reset = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_first_valid", out_valid, 1);
        gaps = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (!out_valid) gaps++;
        end
        check("t1_no_gap", gaps, 0);
        tick();
        wait_drain("t1_drain", 20);

        // Stalled decode: credit limit stops fetching at DEPTH requests.
        out_ready = 1'b0;
        budget = 100;
        do_reset();
        repeat (12) tick();
        check("t2_accepts", acc_cnt, 4);
        check("t2_req_valid", mem_req_valid, 0);
        check("t2_out_valid", out_valid, 1);
        check("t2_out_pc", out_pc, 32'h0);
        repeat (3) tick();
        check("t2_still_accepts", acc_cnt, 4);
        check("t2_still_req", mem_req_valid, 0);
        budget = 4;
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        exp_pc.push_back(32'h8);
        exp_pc.push_back(32'hC);
        out_ready = 1'b1;
        wait_drain("t2_drain", 20);

        // Redirect with two requests in flight: both responses are dropped.
        mem_lat = 3;
        budget  = 2;
        do_reset();
        n = 0;
        while (acc_cnt < 2 && n < 20) begin
            tick();
            n++;
        end
        check("t3_two_accepted", acc_cnt, 2);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        budget = 4;
        exp_pc.push_back(32'h100);
        exp_pc.push_back(32'h104);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_post_out_valid", out_valid, 0);
        check("t3_post_req_valid", mem_req_valid, 1);
        check("t3_post_req_addr", mem_req_addr, 32'h100);
        tick();
        wait_drain("t3_drain", 30);

        // Redirect coinciding with a pop and a response.
        mem_lat = 1;
        budget  = 4;
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        do_reset();
        n = 0;
        while (acc_cnt < 4 && n < 20) begin
            tick();
            n++;
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        budget = 6;
        @(negedge clk);
        check("t4_rsp_in_redirect", mem_rsp_valid, 1);
        check("t4_pop_in_redirect", out_valid, 1);
        check("t4_no_req_in_redirect", mem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        exp_pc.push_back(32'h200);
        exp_pc.push_back(32'h204);
        @(negedge clk);
        check("t4_post_out_valid", out_valid, 0);
        tick();
        wait_drain("t4_drain", 20);

        // Fetch pc wrap-around.
        budget = 0;
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        budget = 2;
        exp_pc.push_back(32'hFFFF_FFFC);
        exp_pc.push_back(32'h0000_0000);
        tick();
        redirect_valid = 1'b0;
        wait_drain("t5_drain", 20);

        // Response-to-output latency with an empty queue.
        budget = 1;
        exp_pc.push_back(32'h0);
        do_reset();
        n = 0;
        @(negedge clk);
        while (!mem_rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_rsp_seen", mem_rsp_valid, 1);
        check("t6_same_cycle", out_valid, BYP);
        @(negedge clk);
        check("t6_next_cycle", out_valid, !BYP);
        tick();
        wait_drain("t6_drain", 10);

        check("no_overflow", overflow, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
